// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - two-port (VID priority, CPU) arbiter for the single SDRAM controller port.
// Optional CPU starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module sdram_port_arbiter #(
  parameter int ADDR_W       = 24,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset_i,
  input  logic                vid_req_i,
  input  logic [ADDR_W-1:0]   vid_addr_i,
  output logic                vid_ack_o,
  output logic [DATA_W-1:0]   vid_rdata_o,
  input  logic                cpu_req_i,
  input  logic                cpu_we_i,
  input  logic [ADDR_W-1:0]   cpu_addr_i,
  input  logic [DATA_W-1:0]   cpu_wdata_i,
  input  logic [DATA_W/8-1:0] cpu_wmask_i,
  output logic                cpu_ack_o,
  output logic [DATA_W-1:0]   cpu_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wmask_o,
  input  logic                mem_ack_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;
  typedef enum logic {OWN_VID, OWN_CPU} owner_t;

  state_t state;
  owner_t owner;
  logic   guard_trip;
  logic   grant_vid;
  logic   grant_cpu;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt;

  assign guard_trip = (starve_cnt == CNT_W'(STARVE_LIMIT));

  // Counts VID grants that bypassed a waiting CPU; saturates at the limit.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      starve_cnt <= '0;
    end else if (state == ST_IDLE) begin
      if (grant_vid) begin
        if (!cpu_req_i)
          starve_cnt <= '0;
        else if (!guard_trip)
          starve_cnt <= starve_cnt + CNT_W'(1);
      end else if (grant_cpu) begin
        starve_cnt <= '0;
      end
    end
  end
`else
  assign guard_trip = 1'b0;
`endif

  // A tripped guard only yields to the CPU if it is actually waiting.
  assign grant_vid = vid_req_i && !(guard_trip && cpu_req_i);
  assign grant_cpu = cpu_req_i && !grant_vid;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state       <= ST_IDLE;
      owner       <= OWN_VID;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_wmask_o <= '0;
      vid_ack_o   <= 1'b0;
      cpu_ack_o   <= 1'b0;
      vid_rdata_o <= '0;
      cpu_rdata_o <= '0;
    end else begin
      vid_ack_o <= 1'b0;
      cpu_ack_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_vid) begin
            owner       <= OWN_VID;
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= vid_addr_i;
            mem_wdata_o <= '0;
            mem_wmask_o <= '0;
            state       <= ST_BUSY;
          end else if (grant_cpu) begin
            owner       <= OWN_CPU;
            mem_req_o   <= 1'b1;
            mem_we_o    <= cpu_we_i;
            mem_addr_o  <= cpu_addr_i;
            mem_wdata_o <= cpu_wdata_i;
            mem_wmask_o <= cpu_wmask_i;
            state       <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            if (owner == OWN_VID) begin
              vid_rdata_o <= mem_rdata_i;
              vid_ack_o   <= 1'b1;
            end else begin
              cpu_rdata_o <= mem_rdata_i;
              cpu_ack_o   <= 1'b1;
            end
            state <= ST_DONE;
          end
        end
        // One dead cycle lets the served requester drop or renew its request.
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
